// File: rtl/fp_sequencer_pkg.sv
// Shared constants and types for the inference sequencer and its argmax step.
package fp_sequencer_pkg;
   localparam int N_CLASSES = 10;
   localparam int CLS_W     = 4;
   localparam int RESULT_W  = 32;

   typedef logic signed [RESULT_W-1:0] result_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      WAIT   = 3'd2,
      ARGMAX = 3'd3,
      REPORT = 3'd4
   } state_e;
endpackage

// File: rtl/fp_sequencer_argmax_step.sv
// One compare-and-select step of the serial argmax: keeps the incumbent unless
// the candidate is strictly greater, so ties stay with the lower index.
module argmax_step
   import fp_sequencer_pkg::*;
#(
   parameter int DATA_W = RESULT_W,
   parameter int IDX_W  = CLS_W
) (
   input  logic signed [DATA_W-1:0] best,
   input  logic        [IDX_W-1:0]  best_idx,
   input  logic signed [DATA_W-1:0] cand,
   input  logic        [IDX_W-1:0]  cand_idx,
   output logic signed [DATA_W-1:0] next_best,
   output logic        [IDX_W-1:0]  next_idx
);
   logic take;

   assign take      = cand > best;
   assign next_best = take ? cand : best;
   assign next_idx  = take ? cand_idx : best_idx;
endmodule

// File: rtl/fp_sequencer.sv
// Inference sequencer: accepts an image request, starts the tile, captures its
// per-class results, finds the argmax serially and reports it with running stats.
module fp_sequencer
   import fp_sequencer_pkg::*;
#(
   parameter int NUM_CLASSES = N_CLASSES,
   parameter int DATA_W      = RESULT_W,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT     = 65535
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          img_valid,
   output logic                          img_ready,
   input  logic [7:0]                    label_in,
   output logic                          tile_start,
   input  logic                          tile_done,
   input  logic [NUM_CLASSES*DATA_W-1:0] tile_result,
   output logic                          pred_valid,
   input  logic                          pred_ready,
   output logic [CLS_W-1:0]              pred_class,
   output logic                          pred_correct,
   output logic [CNT_W-1:0]              correct_cnt,
   output logic [CNT_W-1:0]              total_cnt,
   input  logic                          clr_stats,
   output logic                          busy,
   output logic                          label_err,
   output logic                          timeout_err,
   output logic [2:0]                    state_dbg
);
   localparam logic [2:0] S_IDLE   = IDLE;
   localparam logic [2:0] S_START  = START;
   localparam logic [2:0] S_WAIT   = WAIT;
   localparam logic [2:0] S_ARGMAX = ARGMAX;
   localparam logic [2:0] S_REPORT = REPORT;

   localparam int               WD_W      = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);
   localparam logic [CLS_W-1:0] IDX_LAST  = CLS_W'(NUM_CLASSES - 1);
   localparam logic [7:0]       LABEL_LIM = 8'(NUM_CLASSES);

   logic [2:0]               state;
   logic signed [DATA_W-1:0] res_q [NUM_CLASSES];
   logic signed [DATA_W-1:0] best_q;
   logic signed [DATA_W-1:0] step_best;
   logic [CLS_W-1:0]         idx_q;
   logic [CLS_W-1:0]         best_idx_q;
   logic [CLS_W-1:0]         step_idx;
   logic [7:0]               label_q;
   logic [WD_W-1:0]          wd_cnt;
   logic                     img_hs;
   logic                     pred_hs;
   logic                     label_bad;
   logic                     wd_expire;

   // Both interfaces are valid/ready: a transfer happens on a rising edge where
   // valid and ready are both high; the producer holds its payload until then.
   assign img_ready  = rst && (state == S_IDLE);
   assign img_hs     = img_valid && img_ready;
   assign pred_valid = (state == S_REPORT);
   assign pred_hs    = pred_valid && pred_ready;
   assign tile_start = (state == S_START);
   assign busy       = (state != S_IDLE);
   assign state_dbg  = state;

   assign label_bad  = label_in >= LABEL_LIM;
   assign wd_expire  = (state == S_WAIT) && !tile_done && (wd_cnt == WD_LAST);

   assign pred_class   = best_idx_q;
   assign pred_correct = pred_valid && (label_q < LABEL_LIM) && (label_q == 8'(best_idx_q));

   argmax_step #(
      .DATA_W (DATA_W),
      .IDX_W  (CLS_W)
   ) u_step (
      .best      (best_q),
      .best_idx  (best_idx_q),
      .cand      (res_q[idx_q]),
      .cand_idx  (idx_q),
      .next_best (step_best),
      .next_idx  (step_idx)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         label_q    <= '0;
         wd_cnt     <= '0;
         idx_q      <= '0;
         best_q     <= '0;
         best_idx_q <= '0;
         for (int i = 0; i < NUM_CLASSES; i++) res_q[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (img_hs) begin
                  label_q <= label_in;
                  state   <= S_START;
               end
            end
            S_START: begin
               wd_cnt <= '0;
               state  <= S_WAIT;
            end
            S_WAIT: begin
               wd_cnt <= wd_cnt + 1'b1;
               if (tile_done) begin
                  for (int i = 0; i < NUM_CLASSES; i++)
                     res_q[i] <= tile_result[i*DATA_W +: DATA_W];
                  best_q     <= tile_result[DATA_W-1:0];
                  best_idx_q <= '0;
                  idx_q      <= CLS_W'(1);
                  state      <= S_ARGMAX;
               end else if (wd_expire) begin
                  state <= S_IDLE;
               end
            end
            S_ARGMAX: begin
               best_q     <= step_best;
               best_idx_q <= step_idx;
               idx_q      <= idx_q + 1'b1;
               if (idx_q == IDX_LAST) state <= S_REPORT;
            end
            S_REPORT: begin
               if (pred_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // A clear wins over any same-cycle count or error set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         correct_cnt <= '0;
         total_cnt   <= '0;
         label_err   <= 1'b0;
         timeout_err <= 1'b0;
      end else if (clr_stats) begin
         correct_cnt <= '0;
         total_cnt   <= '0;
         label_err   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (pred_hs) begin
            if (total_cnt != '1) total_cnt <= total_cnt + 1'b1;
            if (pred_correct && (correct_cnt != '1)) correct_cnt <= correct_cnt + 1'b1;
         end
         if (img_hs && label_bad) label_err <= 1'b1;
         if (wd_expire) timeout_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_fp_sequencer.sv
// Directed and randomized bench for fp_sequencer with a queue-based argmax reference.
module tb_fp_sequencer;
   localparam int NC = 10;
   localparam int DW = 32;
   localparam int CW = 16;
   localparam int TO = 8;

   logic             clk;
   logic             rst;
   logic             img_valid;
   logic             img_ready;
   logic [7:0]       label_in;
   logic             tile_start;
   logic             tile_done;
   logic [NC*DW-1:0] tile_result;
   logic             pred_valid;
   logic             pred_ready;
   logic [3:0]       pred_class;
   logic             pred_correct;
   logic [CW-1:0]    correct_cnt;
   logic [CW-1:0]    total_cnt;
   logic             clr_stats;
   logic             busy;
   logic             label_err;
   logic             timeout_err;
   logic [2:0]       state_dbg;

   fp_sequencer #(
      .NUM_CLASSES (NC),
      .DATA_W      (DW),
      .CNT_W       (CW),
      .TIMEOUT     (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .img_valid    (img_valid),
      .img_ready    (img_ready),
      .label_in     (label_in),
      .tile_start   (tile_start),
      .tile_done    (tile_done),
      .tile_result  (tile_result),
      .pred_valid   (pred_valid),
      .pred_ready   (pred_ready),
      .pred_class   (pred_class),
      .pred_correct (pred_correct),
      .correct_cnt  (correct_cnt),
      .total_cnt    (total_cnt),
      .clr_stats    (clr_stats),
      .busy         (busy),
      .label_err    (label_err),
      .timeout_err  (timeout_err),
      .state_dbg    (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         res [NC];
   logic [3:0] exp_q [$];
   int         exp_total = 0;
   int         exp_correct = 0;
   bit         exp_label_err = 0;
   bit         exp_timeout_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // First index holding the largest signed value.
   function automatic int ref_argmax();
      int best_i = 0;
      for (int i = 1; i < NC; i++)
         if (res[i] > res[best_i]) best_i = i;
      return best_i;
   endfunction

   task automatic load_results();
      for (int i = 0; i < NC; i++) tile_result[i*DW +: DW] = res[i];
   endtask

   task automatic load_junk();
      for (int i = 0; i < NC; i++) tile_result[i*DW +: DW] = $urandom;
   endtask

   task automatic model_clear();
      exp_total = 0;
      exp_correct = 0;
      exp_label_err = 0;
      exp_timeout_err = 0;
   endtask

   task automatic check_stats(input string tag);
      check({tag, "_total"}, total_cnt, exp_total);
      check({tag, "_correct"}, correct_cnt, exp_correct);
      check({tag, "_label_err"}, label_err, exp_label_err);
      check({tag, "_timeout_err"}, timeout_err, exp_timeout_err);
   endtask

   task automatic handshake_to_wait(input int label);
      check("img_ready_idle", img_ready, 1);
      img_valid = 1'b1;
      label_in  = 8'(label);
      @(posedge clk); #1;
      img_valid = 1'b0;
      label_in  = 8'($urandom);
      if (label >= NC) exp_label_err = 1;
      check("tile_start_pulse", tile_start, 1);
      check("img_ready_after_hs", img_ready, 0);
      check("label_err_at_hs", label_err, exp_label_err);
      @(posedge clk); #1;
      check("tile_start_once", tile_start, 0);
   endtask

   task automatic run_inference(input int label, input int done_dly, input int ready_dly,
                                input bit clr_mid, input bit clr_at_hs);
      int         exp_cls;
      bit         exp_ok;
      int         lat;
      logic [3:0] want;
      exp_cls = ref_argmax();
      exp_ok  = (label < NC) && (exp_cls == label);
      exp_q.push_back(4'(exp_cls));
      handshake_to_wait(label);
      for (int i = 0; i < done_dly; i++) begin
         @(posedge clk); #1;
      end
      tile_done = 1'b1;
      load_results();
      @(posedge clk); #1;
      tile_done = 1'b0;
      lat = 1;
      while (pred_valid !== 1'b1 && lat < 40) begin
         load_junk();
         tile_done = 1'($urandom);
         clr_stats = clr_mid && (lat == 3);
         if (clr_stats) model_clear();
         @(posedge clk); #1;
         clr_stats = 1'b0;
         lat++;
      end
      tile_done = 1'b0;
      check("pred_latency", lat, NC);
      want = exp_q.pop_front();
      for (int i = 0; i < ready_dly; i++) begin
         check("hold_pred_valid", pred_valid, 1);
         check("hold_pred_class", pred_class, want);
         check("hold_pred_correct", pred_correct, exp_ok);
         check("hold_img_ready", img_ready, 0);
         @(posedge clk); #1;
      end
      check("pred_class", pred_class, want);
      check("pred_correct", pred_correct, exp_ok);
      pred_ready = 1'b1;
      clr_stats  = clr_at_hs;
      @(posedge clk); #1;
      pred_ready = 1'b0;
      clr_stats  = 1'b0;
      if (clr_at_hs) model_clear();
      else begin
         if (exp_total < 65535) exp_total++;
         if (exp_ok && exp_correct < 65535) exp_correct++;
      end
      check("pred_valid_dropped", pred_valid, 0);
      check("img_ready_back", img_ready, 1);
      check_stats("stats");
   endtask

   initial begin
      int n;
      bit seen_pred;
      rst         = 1'b1;
      img_valid   = 1'b0;
      label_in    = '0;
      tile_done   = 1'b0;
      tile_result = '0;
      pred_ready  = 1'b0;
      clr_stats   = 1'b0;
      #3 rst = 1'b0;
      #1;
      check("rst_img_ready", img_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_pred_valid", pred_valid, 0);
      check("rst_state", state_dbg, 0);
      check_stats("rst");
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1 check("img_ready_after_release", img_ready, 1);
      @(posedge clk); #1;
      check("img_ready_first_cycle", img_ready, 1);

      // Clear winner at index 3, tile_done four cycles after the start pulse.
      for (int i = 0; i < NC; i++) res[i] = 1;
      res[0] = 5;
      res[3] = 100;
      run_inference(3, 3, 0, 0, 0);
      check("basic_total_is_1", total_cnt, 1);
      check("basic_correct_is_1", correct_cnt, 1);

      for (int i = 0; i < NC; i++) res[i] = -7;
      run_inference(0, 1, 1, 0, 0);
      for (int i = 0; i < NC; i++) res[i] = -50;
      res[2] = -1;
      run_inference(5, 0, 0, 0, 0);

      // Out-of-range label: counted but never correct.
      res[7] = 3;
      run_inference(12, 2, 0, 0, 0);

      // Watchdog: tile never answers.
      handshake_to_wait(1);
      n = 1;
      seen_pred = 0;
      while (busy === 1'b1 && n < 30) begin
         if (pred_valid === 1'b1) seen_pred = 1;
         @(posedge clk); #1;
         n++;
      end
      exp_timeout_err = 1;
      check("timeout_wait_cycles", n - 1, TO);
      check("timeout_no_pred", seen_pred, 0);
      check("timeout_idle", img_ready, 1);
      check_stats("timeout");

      // Consumer stalls five cycles, then clears stats on the same handshake.
      for (int i = 0; i < NC; i++) res[i] = int'($urandom_range(0, 20));
      run_inference(4, 2, 5, 0, 1);
      check("clr_at_hs_total", total_cnt, 0);

      // Clear during ARGMAX must not disturb the inference.
      for (int i = 0; i < NC; i++) res[i] = int'($urandom_range(0, 40)) - 20;
      run_inference(ref_argmax(), 4, 2, 1, 0);

      // Reset in the middle of ARGMAX.
      for (int i = 0; i < NC; i++) res[i] = 9;
      handshake_to_wait(2);
      tile_done = 1'b1;
      load_results();
      @(posedge clk); #1;
      tile_done = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      model_clear();
      check("midrst_busy", busy, 0);
      check("midrst_img_ready", img_ready, 0);
      check("midrst_pred_valid", pred_valid, 0);
      check("midrst_pred_class", pred_class, 0);
      check("midrst_pred_correct", pred_correct, 0);
      check_stats("midrst");
      #2 rst = 1'b1;
      #1 check("midrst_img_ready_release", img_ready, 1);
      @(posedge clk); #1;
      for (int i = 0; i < NC; i++) res[i] = int'($urandom_range(0, 100));
      res[6] = 200;
      run_inference(6, 1, 0, 0, 0);

      for (int t = 0; t < 25; t++) begin
         bit wide;
         wide = 1'($urandom);
         for (int i = 0; i < NC; i++)
            res[i] = wide ? int'($urandom) : int'($urandom_range(0, 6)) - 3;
         run_inference(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : ref_argmax(),
                       int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 0, 0);
      end
      check("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
